de_pipe_reg: RTL and testbench
==============================

// Module: de_pipe_reg
// PURPOSE
//  Decode->Execute pipeline register; consumes the hazard controller's stall/flush outputs.
//  Holds, loads or bubbles the D/E payload each cycle.
//  Reports pipeline state, flags hazard-protocol violations and watchdogs long stalls.
//  Sits between the decode stage / hazard_controller and the execute stage / forwarding muxes.
// PARAMETERS
//  DATA_W      32  width of operand data and immediate
//  REG_AW      6   register-address width (rs/rt/rd)
//  CTRL_W      12  width of the packed decode control word
//  WDOG_LIMIT  16  consecutive e_stall cycles that trip wdog_timeout (>=2)
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high reset
//  d_valid       in   1       decode stage holds a real instruction
//  d_rs,d_rt,d_rd in  REG_AW  decode register addresses
//  d_rd1,d_rd2   in   DATA_W  register-file read data
//  d_imm         in   DATA_W  sign/zero-extended immediate
//  d_ctrl        in   CTRL_W  decode control word
//  d_stall       in   1       hazard controller: decode frozen
//  e_flush       in   1       hazard controller: bubble into execute
//  e_stall       in   1       execute busy (multi-cycle unit): hold E
//  e_valid       out  1       execute stage holds a real instruction
//  e_rs,e_rt,e_rd out REG_AW  registered addresses (feed hazard_controller)
//  e_rd1,e_rd2,e_imm out DATA_W registered data
//  e_ctrl        out  CTRL_W  registered control word
//  e_state       out  2       0=RUN 1=HOLD 2=BUBBLE (3 never driven)
//  hz_err        out  1       sticky: d_stall seen without e_flush/e_stall
//  wdog_timeout  out  1       sticky: e_stall held >= WDOG_LIMIT cycles
//  flush_cnt     out  16      bubbles inserted (STALL_PERF_EN only)
//  stall_cnt     out  16      hold cycles (STALL_PERF_EN only)
// BEHAVIOUR
//  - Reset: every output 0; e_state=RUN; watchdog counter 0. Reset beats all other inputs.
//  - Per-cycle priority (evaluated when not in reset):
//    1 e_flush=1: load bubble -> e_valid=0; e_rs/e_rt/e_rd/e_rd1/e_rd2/e_imm/e_ctrl=0; e_state=BUBBLE.
//    2 else e_stall=1: all payload held unchanged; e_state=HOLD.
//    3 else d_stall=1: illegal (would duplicate the instruction) -> load bubble as in 1;
//      hz_err<=1; e_state=BUBBLE.
//    4 else: load all d_* fields, e_valid<=d_valid; e_state=RUN.
//  - e_flush together with e_stall: flush wins; the watchdog counter clears.
//  - Latency: one cycle D->E; no combinational path from inputs to outputs.
//  - A bubble has e_ctrl=0, so RF write-enable/memory controls are off.
//    Zeroed addresses make forwarding compares hit only register 0.
//  - Watchdog:
//    * counter increments on each cycle of case 2; clears on any other case.
//    * counter saturates at WDOG_LIMIT.
//    * wdog_timeout<=1 on the cycle the count reaches WDOG_LIMIT.
//  - hz_err and wdog_timeout clear only on reset.
//  - Reset asserted mid-stall: all state, counters and sticky flags return to 0 on that edge.
//  - FSM transitions: any state -> BUBBLE/HOLD/RUN purely per the priority above;
//    there are no multi-cycle sequences.
// CONFIGURATION
//  STALL_PERF_EN defined:
//   * flush_cnt +1 per cycle in case 1 or 3; stall_cnt +1 per cycle in case 2.
//   * both are 16-bit and saturate at 16'hFFFF; reset to 0.
//  STALL_PERF_EN undefined:
//   * flush_cnt/stall_cnt are tied to 0.
//   * no counter flops are generated.
// TESTING
//  T1 reset=1 for 1 cycle with random inputs -> all outputs 0, e_state=0.
//  T2 d_valid=1, d_rs=5, d_rt=7, d_rd=9, d_rd1=32'hDEAD_BEEF, d_ctrl=12'h0A5, no hazards
//     -> next cycle e_rs=5, e_rt=7, e_rd=9, e_rd1=32'hDEAD_BEEF, e_ctrl=12'h0A5, e_valid=1, e_state=RUN.
//  T3 load-use: d_stall=1,e_flush=1 for 1 cycle -> e_valid=0, e_ctrl=0, e_state=BUBBLE, hz_err=0;
//     flush_cnt=1 with STALL_PERF_EN.
//  T4 e_stall=1 for 3 cycles while d_* change -> e_* keep prior values, e_state=HOLD;
//     stall_cnt=3 with STALL_PERF_EN; wdog_timeout=0.
//  T5 e_stall=1 for WDOG_LIMIT=16 cycles -> wdog_timeout=1 after 16th edge;
//     stays 1 after e_stall drops; cleared by reset.
//  T6 d_stall=1,e_flush=0,e_stall=0 -> bubble loaded, hz_err=1 (sticky);
//     e_flush=1 with e_stall=1 -> bubble, watchdog counter 0.

Source files
------------

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: decode->execute pipeline register with hazard checking, stall watchdog and optional STALL_PERF_EN counters
module de_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 6,
  parameter int CTRL_W     = 12,
  parameter int WDOG_LIMIT = 16
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [REG_AW-1:0] d_rd,
  input  logic [DATA_W-1:0] d_rd1,
  input  logic [DATA_W-1:0] d_rd2,
  input  logic [DATA_W-1:0] d_imm,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              d_stall,
  input  logic              e_flush,
  input  logic              e_stall,
  output logic              e_valid,
  output logic [REG_AW-1:0] e_rs,
  output logic [REG_AW-1:0] e_rt,
  output logic [REG_AW-1:0] e_rd,
  output logic [DATA_W-1:0] e_rd1,
  output logic [DATA_W-1:0] e_rd2,
  output logic [DATA_W-1:0] e_imm,
  output logic [CTRL_W-1:0] e_ctrl,
  output logic [1:0]        e_state,
  output logic              hz_err,
  output logic              wdog_timeout,
  output logic [15:0]       flush_cnt,
  output logic [15:0]       stall_cnt
);
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, BUBBLE = 2'd2} state_t;
  state_t st;
  logic [WW-1:0] wcnt;
  logic bub;
  assign bub = e_flush | (~e_stall & d_stall);
  assign e_state = st;
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid      <= 1'b0;
      e_rs         <= '0;
      e_rt         <= '0;
      e_rd         <= '0;
      e_rd1        <= '0;
      e_rd2        <= '0;
      e_imm        <= '0;
      e_ctrl       <= '0;
      st           <= RUN;
      hz_err       <= 1'b0;
      wdog_timeout <= 1'b0;
      wcnt         <= '0;
    end else if (bub) begin
      e_valid <= 1'b0;
      e_rs    <= '0;
      e_rt    <= '0;
      e_rd    <= '0;
      e_rd1   <= '0;
      e_rd2   <= '0;
      e_imm   <= '0;
      e_ctrl  <= '0;
      st      <= BUBBLE;
      hz_err  <= hz_err | ~e_flush;
      wcnt    <= '0;
    end else if (e_stall) begin
      st           <= HOLD;
      wcnt         <= (wcnt == WW'(WDOG_LIMIT)) ? wcnt : wcnt + 1'b1;
      wdog_timeout <= wdog_timeout | (wcnt >= WW'(WDOG_LIMIT - 1));
    end else begin
      e_valid <= d_valid;
      e_rs    <= d_rs;
      e_rt    <= d_rt;
      e_rd    <= d_rd;
      e_rd1   <= d_rd1;
      e_rd2   <= d_rd2;
      e_imm   <= d_imm;
      e_ctrl  <= d_ctrl;
      st      <= RUN;
      wcnt    <= '0;
    end
  end
`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      flush_cnt <= (bub && flush_cnt != 16'hFFFF) ? flush_cnt + 1'b1 : flush_cnt;
      stall_cnt <= (!bub && e_stall && stall_cnt != 16'hFFFF) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
`else
  assign flush_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg: directed-vector scoreboard bench for de_pipe_reg
module tb_de_pipe_reg;
  typedef struct packed {
    logic [5:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [11:0] ctrl;
  } pay_t;
  typedef struct packed {
    logic        ev;
    pay_t        p;
    logic [1:0]  st;
    logic        hz, wd;
    logic [15:0] fc, sc;
  } exp_t;
  localparam pay_t P0 = '0;
  localparam pay_t P1 = '{rs: 6'd5, rt: 6'd7, rd: 6'd9, rd1: 32'hDEAD_BEEF, rd2: 32'h1234_5678, imm: 32'hFFFF_FFF0, ctrl: 12'h0A5};
  localparam pay_t P2 = '{rs: 6'd3, rt: 6'd4, rd: 6'd6, rd1: 32'hA5A5_0001, rd2: 32'h0000_0002, imm: 32'h0000_0010, ctrl: 12'h3C1};
  localparam pay_t P3 = '{rs: 6'd63, rt: 6'd1, rd: 6'd2, rd1: 32'h0BAD_F00D, rd2: 32'hCAFE_0000, imm: 32'h7FFF_FFFF, ctrl: 12'hFFF};
  logic clk = 0, reset = 1, d_valid = 0, d_stall = 0, e_flush = 0, e_stall = 0;
  logic [5:0] d_rs = 0, d_rt = 0, d_rd = 0, e_rs, e_rt, e_rd;
  logic [31:0] d_rd1 = 0, d_rd2 = 0, d_imm = 0, e_rd1, e_rd2, e_imm;
  logic [11:0] d_ctrl = 0, e_ctrl;
  logic e_valid, hz_err, wdog_timeout;
  logic [1:0] e_state;
  logic [15:0] flush_cnt, stall_cnt;
  exp_t q[$];
  int vid[$];
  int checks = 0, errors = 0, n = 0;
  de_pipe_reg dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_ctrl(d_ctrl), .d_stall(d_stall),
    .e_flush(e_flush), .e_stall(e_stall), .e_valid(e_valid), .e_rs(e_rs), .e_rt(e_rt),
    .e_rd(e_rd), .e_rd1(e_rd1), .e_rd2(e_rd2), .e_imm(e_imm), .e_ctrl(e_ctrl),
    .e_state(e_state), .hz_err(hz_err), .wdog_timeout(wdog_timeout),
    .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic dv, input pay_t din, input logic ds, ef, es,
                      input logic ev, input pay_t eo, input logic [1:0] st, input logic hz, wd,
                      input logic [15:0] fc, sc);
    exp_t x;
    @(negedge clk);
    reset = r; d_valid = dv; d_stall = ds; e_flush = ef; e_stall = es;
    {d_rs, d_rt, d_rd, d_rd1, d_rd2, d_imm, d_ctrl} = din;
`ifdef STALL_PERF_EN
    x = '{ev: ev, p: eo, st: st, hz: hz, wd: wd, fc: fc, sc: sc};
`else
    x = '{ev: ev, p: eo, st: st, hz: hz, wd: wd, fc: 16'd0, sc: 16'd0};
`endif
    q.push_back(x);
    vid.push_back(n);
    n++;
  endtask
  initial begin
    exp_t a, x;
    int id;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        id = vid.pop_front();
        a = '{ev: e_valid, p: '{rs: e_rs, rt: e_rt, rd: e_rd, rd1: e_rd1, rd2: e_rd2, imm: e_imm, ctrl: e_ctrl},
              st: e_state, hz: hz_err, wd: wdog_timeout, fc: flush_cnt, sc: stall_cnt};
        checks++;
        if (a !== x) begin
          errors++;
          $display("FAIL vec%0d got %h want %h", id, a, x);
        end
      end
    end
  end
  initial begin
    pay_t r;
    r.rs = 6'($urandom()); r.rt = 6'($urandom()); r.rd = 6'($urandom());
    r.rd1 = $urandom(); r.rd2 = $urandom(); r.imm = $urandom(); r.ctrl = 12'($urandom());
    step(1, 1, r, 1, 1, 1,  0, P0, 2'd0, 0, 0, 0, 0);
    step(0, 1, P1, 0, 0, 0, 1, P1, 2'd0, 0, 0, 0, 0);
    step(0, 1, P2, 1, 1, 0, 0, P0, 2'd2, 0, 0, 1, 0);
    step(0, 1, P2, 0, 0, 0, 1, P2, 2'd0, 0, 0, 1, 0);
    step(0, 1, P1, 0, 0, 1, 1, P2, 2'd1, 0, 0, 1, 1);
    step(0, 0, P3, 1, 0, 1, 1, P2, 2'd1, 0, 0, 1, 2);
    step(0, 1, P3, 0, 0, 1, 1, P2, 2'd1, 0, 0, 1, 3);
    step(0, 0, P1, 0, 0, 0, 0, P1, 2'd0, 0, 0, 1, 3);
    for (int i = 0; i < 16; i++)
      step(0, 1, (i % 2) ? P2 : P3, 0, 0, 1, 0, P1, 2'd1, 0, i == 15, 1, 16'(4 + i));
    step(0, 1, P2, 0, 0, 0, 1, P2, 2'd0, 0, 1, 1, 19);
    step(1, 1, P3, 0, 0, 1, 0, P0, 2'd0, 0, 0, 0, 0);
    step(0, 1, P1, 1, 0, 0, 0, P0, 2'd2, 1, 0, 1, 0);
    step(0, 1, P1, 0, 0, 0, 1, P1, 2'd0, 1, 0, 1, 0);
    step(0, 1, P2, 0, 0, 1, 1, P1, 2'd1, 1, 0, 1, 1);
    step(0, 1, P2, 0, 0, 1, 1, P1, 2'd1, 1, 0, 1, 2);
    step(0, 1, P2, 0, 1, 1, 0, P0, 2'd2, 1, 0, 2, 2);
    for (int i = 0; i < 16; i++)
      step(0, 1, P3, 0, 0, 1, 0, P0, 2'd1, 1, i == 15, 2, 16'(3 + i));
    step(1, 1, P3, 1, 0, 1, 0, P0, 2'd0, 0, 0, 0, 0);
    step(0, 1, P3, 0, 0, 0, 1, P3, 2'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 0; e_stall = 0; d_stall = 0; e_flush = 0;
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
